// File: rtl/fib_pkg.sv
// Shared types and register-file addresses for the Fibonacci sequencer.
package fib_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInitA,
        StInitB,
        StAdd,
        StShift1,
        StShift2,
        StFinish,
        StDone
    } fib_state_e;

    localparam logic [1:0] RF_ZERO = 2'b00;
    localparam logic [1:0] RF_PREV = 2'b01;
    localparam logic [1:0] RF_CURR = 2'b10;
    localparam logic [1:0] RF_TMP  = 2'b11;

    // Number of loop iterations for index n, i.e. max(n-1, 0).
    function automatic logic [7:0] loop_count(input logic [7:0] n);
        return (n == 8'd0) ? 8'd0 : n - 8'd1;
    endfunction

endpackage

// File: rtl/fib_loop_counter.sv
// Loadable down-counter for the Fibonacci loop; saturates at zero.
module fib_loop_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == Width'(1));

endmodule

// File: rtl/fib_sequencer.sv
// Drives a 4-entry register file to compute F(n) with a start/busy/done handshake.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int unsigned REGF_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  n_i,
    input  logic [REGF_WIDTH-1:0] reg1_i,
    input  logic [REGF_WIDTH-1:0] reg2_i,
    output logic [1:0]            write_o,
    output logic [1:0]            read1_o,
    output logic [1:0]            read2_o,
    output logic [REGF_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [REGF_WIDTH-1:0] result_o,
    output logic                  overflow_o
);

    fib_state_e            state_q;
    logic [CNT_WIDTH-1:0]  n_q;
    logic [REGF_WIDTH-1:0] result_q;
    logic                  overflow_q;
    logic                  busy_q;
    logic                  done_q;

    logic [REGF_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0]  cnt_load_val;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_is_one;
    logic                  cnt_is_zero;

    assign sum          = {1'b0, reg1_i} + {1'b0, reg2_i};
    assign cnt_load_val = (n_i == '0) ? '0 : n_i - CNT_WIDTH'(1);
    assign cnt_load     = (state_q == StIdle) && start_i;
    assign cnt_dec      = (state_q == StShift2);

    fib_loop_counter #(
        .Width (CNT_WIDTH)
    ) u_loop_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_is_one),
        .is_zero_o  (cnt_is_zero)
    );

    // Register-file selects are Moore decodes; the file reads combinationally and
    // writes at the next edge, so each state reads and writes in the same cycle.
    always_comb begin
        write_o = RF_ZERO;
        read1_o = RF_ZERO;
        read2_o = RF_ZERO;
        data_o  = '0;
        unique case (state_q)
            StInitA: begin
                write_o = RF_PREV;
            end
            StInitB: begin
                write_o = RF_CURR;
                data_o  = REGF_WIDTH'(1);
            end
            StAdd: begin
                read1_o = RF_PREV;
                read2_o = RF_CURR;
                write_o = RF_TMP;
                data_o  = sum[REGF_WIDTH-1:0];
            end
            StShift1: begin
                read1_o = RF_CURR;
                write_o = RF_PREV;
                data_o  = reg1_i;
            end
            StShift2: begin
                read1_o = RF_TMP;
                write_o = RF_CURR;
                data_o  = reg1_i;
            end
            StFinish: begin
                read2_o = RF_CURR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            n_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StInitA;
                        busy_q     <= 1'b1;
                        n_q        <= n_i;
                        overflow_q <= 1'b0;
                        result_q   <= '0;
                    end
                end
                StInitA: state_q <= StInitB;
                StInitB: state_q <= cnt_is_zero ? StFinish : StAdd;
                StAdd: begin
                    overflow_q <= overflow_q | sum[REGF_WIDTH];
                    state_q    <= StShift1;
                end
                StShift1: state_q <= StShift2;
                // Counter still holds the pre-decrement value here.
                StShift2: state_q <= cnt_is_one ? StFinish : StAdd;
                StFinish: begin
                    result_q <= (n_q == '0) ? '0 : reg2_i;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench: fib_sequencer wired to a 4-entry register file model.
module tb_fib_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] n_i = '0;
    logic [W-1:0]  reg1, reg2, data;
    logic [1:0]    write_sel, read1_sel, read2_sel;
    logic          busy_o, done_o, overflow_o;
    logic [W-1:0]  result_o;

    always #5 clk = ~clk;

    fib_sequencer #(
        .REGF_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .n_i        (n_i),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .write_o    (write_sel),
        .read1_o    (read1_sel),
        .read2_o    (read2_sel),
        .data_o     (data),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .overflow_o (overflow_o)
    );

    // Register file: combinational reads, write at edge, select 00 means no write.
    logic [W-1:0] rf_q [4];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else if (write_sel != 2'b00) begin
            rf_q[write_sel] <= data;
        end
    end
    assign reg1 = rf_q[read1_sel];
    assign reg2 = rf_q[read2_sel];

    int unsigned cyc = 0;
    int unsigned wr11_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && write_sel == 2'b11) wr11_cnt <= wr11_cnt + 1;
    end

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int unsigned  k;
        int unsigned  start_edge;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: F(n-1), F(n) mod 2^W and whether the exact F(n) reaches 2^W.
    function automatic void fib_model(input int unsigned n, output logic [W-1:0] prev,
                                      output logic [W-1:0] cur, output logic ovf);
        int unsigned am = 0, bm = 1, tm;
        longint ae = 0, be = 1, te;
        for (int i = 1; i < int'(n); i++) begin
            tm = (am + bm) % 65536;
            am = bm;
            bm = tm;
            te = ae + be;
            if (te > 64'd1048576) te = 64'd1048576;
            ae = be;
            be = te;
        end
        prev = am[W-1:0];
        cur  = bm[W-1:0];
        ovf  = (be >= 65536);
    endfunction

    function automatic exp_t make_exp(input int unsigned n, input int unsigned edge_idx);
        exp_t e;
        logic [W-1:0] p, c;
        logic o;
        fib_model(n, p, c, o);
        e.res        = (n == 0) ? '0 : c;
        e.ovf        = o;
        e.k          = (n == 0) ? 0 : n - 1;
        e.start_edge = edge_idx;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result_o, e.res);
                    check("overflow", overflow_o, e.ovf);
                    check("done_latency", cyc - e.start_edge, 3 + 3 * e.k);
                end
            end
        end
    end

    task automatic issue(input int unsigned n);
        @(negedge clk);
        start_i = 1'b1;
        n_i     = CW'(n);
        sb_q.push_back(make_exp(n, cyc + 1));
        @(negedge clk);
        start_i = 1'b0;
        n_i     = CW'($urandom_range(0, 255));
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy_o) check("idle_timeout", 1, 0);
    endtask

    task automatic run(input int unsigned n);
        logic [W-1:0] p, c;
        logic o;
        issue(n);
        wait_idle();
        fib_model(n, p, c, o);
        check("rf_r1", rf_q[1], (n == 0) ? 0 : p);
        check("rf_r2", rf_q[2], (n == 0) ? 1 : c);
        check("result_hold", result_o, (n == 0) ? 0 : c);
    endtask

    initial begin
        int unsigned c0;
        int t;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result", result_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_write", write_sel, 0);
        reset = 1'b1;

        run(10);
        check("n10_result", result_o, 55);

        wr11_cnt = 0;
        run(0);
        run(1);
        check("no_add_for_n0_n1", wr11_cnt, 0);

        run(24);
        run(25);
        check("n25_overflow", overflow_o, 1);
        run(5);
        check("overflow_cleared", overflow_o, 0);

        // start held through a whole run; n_i wanders except at the acceptance edges.
        @(negedge clk);
        c0 = cyc;
        start_i = 1'b1;
        n_i = 8'd6;
        sb_q.push_back(make_exp(6, c0 + 1));
        sb_q.push_back(make_exp(6, c0 + 21));
        while (cyc < c0 + 21) begin
            @(negedge clk);
            n_i = (cyc + 1 == c0 + 21) ? 8'd6 : CW'($urandom_range(0, 255));
        end
        start_i = 1'b0;
        wait_idle();
        check("held_start_drained", sb_q.size(), 0);

        // Reset during ADD of a long run.
        issue(20);
        t = 0;
        while (write_sel != 2'b11 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_add", write_sel, 2'b11);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_result", result_o, 0);
        check("midrst_write", write_sel, 0);
        check("midrst_overflow", overflow_o, 0);
        check("midrst_rf_r2", rf_q[2], 0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run(7);

        run(255);
        repeat (12) run($urandom_range(0, 40));

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
- Control-and-datapath stage wrapped around the 4-entry register file. Computes Fibonacci F(n) by driving the file's write/read1/read2 selects, consuming the reg1/reg2 read data, and feeding the sum back on Data.
- Start/busy/done handshake toward the lab top level. Result is captured in a local register.

Parameters:
- REGF_WIDTH, 16, data width; must equal the register file's REGF_WIDTH.
- CNT_WIDTH, 8, width of the n operand and the internal loop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset. Shared with the register file.
- start  in  1  request pulse; sampled only in IDLE.
- n  in  CNT_WIDTH  Fibonacci index; latched when start is accepted.
- reg1  in  REGF_WIDTH  register file read port 1 data.
- reg2  in  REGF_WIDTH  register file read port 2 data.
- write  out  2  register file write select; 00 = no write.
- read1  out  2  register file read select 1.
- read2  out  2  register file read select 2.
- Data  out  REGF_WIDTH  register file write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  REGF_WIDTH  F(n) mod 2^REGF_WIDTH; holds until next accepted start.
- overflow  out  1  sticky; set if any add carried out during the current run.

Behaviour:
- Register map: r0 = zero (never written), r1 = F(k-1), r2 = F(k), r3 = temp sum.
- Reset (async, active-low): state IDLE; result, overflow, done, busy, loop counter all 0. Register file reset clears r0..r3 concurrently.
- Register file reads are combinational and writes land at the next edge, so each state reads and writes in the same cycle. Select and Data outputs are Moore decodes of state; Data in ADD is combinational from reg1/reg2.
- States and outputs:
  - IDLE: write=00, read1=read2=00, Data=0. start=1 -> INIT_A. Latch n; cnt <= max(n-1,0); clear overflow and result.
  - INIT_A: write=01, Data=0 -> INIT_B.
  - INIT_B: write=10, Data=1. Next is FINISH if cnt==0, else ADD.
  - ADD: read1=01, read2=10, Data=reg1+reg2 (low REGF_WIDTH bits), write=11. overflow <= overflow | carry -> SHIFT1.
  - SHIFT1: read1=10, Data=reg1, write=01 -> SHIFT2.
  - SHIFT2: read1=11, Data=reg1, write=10. cnt <= cnt-1. Next is FINISH if cnt==1, else ADD.
  - FINISH: read2=10, write=00. result <= (n_q==0) ? 0 : reg2 -> DONE.
  - DONE: done=1 for exactly this cycle, write=00 -> IDLE.
- Latency: with k = max(n-1,0), done is high in the cycle after the (3+3k)-th rising edge following the start-sampling edge.
- start while busy: ignored; no effect on n_q, cnt or state.
- n=0 and n=1 skip the loop entirely.
- Counter never underflows. n at its maximum value is legal, since n-1 fits in CNT_WIDTH.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. No done pulse. Partial register file contents are cleared by the shared reset.
- Overflow does not abort the run. Result is the truncated value.

Decomposition:
- Shared package fib_pkg:
  - state enum: IDLE, INIT_A, INIT_B, ADD, SHIFT1, SHIFT2, FINISH, DONE.
  - register address constants: RF_ZERO=2'b00, RF_PREV=2'b01, RF_CURR=2'b10, RF_TMP=2'b11.
- One sub-module: fib_loop_counter, a loadable down-counter with load, decrement and is_one/is_zero flags.
- Bench instantiates fib_sequencer wired to the real register file.

Test Plan:
- Reset, then start with n=10 -> busy=1 next cycle; done pulses 30 edges after the start edge; result=55; overflow=0; r1=34, r2=55.
- n=0 -> done 3 edges after start; result=0. n=1 -> done 3 edges after start; result=1. No write=11 cycle in either run.
- n=24 -> result=46368, overflow=0. n=25 -> result=9489 (75025 mod 65536), overflow=1. Next run n=5 -> overflow cleared, result=5.
- start held high through a whole n=6 run -> second start accepted only in the IDLE cycle after done; each run gives result=8; mid-run starts have no effect.
- Drop reset low during ADD of an n=20 run -> busy, done, result, write all 0 immediately. Next run n=7 -> result=13.
